// File: rtl/axi_bridge_2m_arbiter.sv
// axi_bridge_2m_arbiter: two-master AXI3 arbiter serialising bursts onto one bridge slave port
`timescale 1ns/1ps
module axi_bridge_2m_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int AXI_DWIDTH = 64,
  parameter int ID_WIDTH   = 5
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [ADDR_WIDTH-1:0]   M0_AWADDR,
  input  logic [3:0]              M0_AWLEN,
  input  logic [2:0]              M0_AWSIZE,
  input  logic [1:0]              M0_AWBURST,
  input  logic [ID_WIDTH-1:0]     M0_AWID,
  input  logic                    M0_AWVALID,
  output logic                    M0_AWREADY,
  input  logic [AXI_DWIDTH-1:0]   M0_WDATA,
  input  logic [AXI_DWIDTH/8-1:0] M0_WSTRB,
  input  logic                    M0_WLAST,
  input  logic                    M0_WVALID,
  output logic                    M0_WREADY,
  output logic [ID_WIDTH-1:0]     M0_BID,
  output logic [1:0]              M0_BRESP,
  output logic                    M0_BVALID,
  input  logic                    M0_BREADY,
  input  logic [ADDR_WIDTH-1:0]   M0_ARADDR,
  input  logic [3:0]              M0_ARLEN,
  input  logic [2:0]              M0_ARSIZE,
  input  logic [1:0]              M0_ARBURST,
  input  logic [ID_WIDTH-1:0]     M0_ARID,
  input  logic                    M0_ARVALID,
  output logic                    M0_ARREADY,
  output logic [ID_WIDTH-1:0]     M0_RID,
  output logic [AXI_DWIDTH-1:0]   M0_RDATA,
  output logic [1:0]              M0_RRESP,
  output logic                    M0_RLAST,
  output logic                    M0_RVALID,
  input  logic                    M0_RREADY,
  input  logic [ADDR_WIDTH-1:0]   M1_AWADDR,
  input  logic [3:0]              M1_AWLEN,
  input  logic [2:0]              M1_AWSIZE,
  input  logic [1:0]              M1_AWBURST,
  input  logic [ID_WIDTH-1:0]     M1_AWID,
  input  logic                    M1_AWVALID,
  output logic                    M1_AWREADY,
  input  logic [AXI_DWIDTH-1:0]   M1_WDATA,
  input  logic [AXI_DWIDTH/8-1:0] M1_WSTRB,
  input  logic                    M1_WLAST,
  input  logic                    M1_WVALID,
  output logic                    M1_WREADY,
  output logic [ID_WIDTH-1:0]     M1_BID,
  output logic [1:0]              M1_BRESP,
  output logic                    M1_BVALID,
  input  logic                    M1_BREADY,
  input  logic [ADDR_WIDTH-1:0]   M1_ARADDR,
  input  logic [3:0]              M1_ARLEN,
  input  logic [2:0]              M1_ARSIZE,
  input  logic [1:0]              M1_ARBURST,
  input  logic [ID_WIDTH-1:0]     M1_ARID,
  input  logic                    M1_ARVALID,
  output logic                    M1_ARREADY,
  output logic [ID_WIDTH-1:0]     M1_RID,
  output logic [AXI_DWIDTH-1:0]   M1_RDATA,
  output logic [1:0]              M1_RRESP,
  output logic                    M1_RLAST,
  output logic                    M1_RVALID,
  input  logic                    M1_RREADY,
  output logic [ADDR_WIDTH-1:0]   S_AWADDR,
  output logic [3:0]              S_AWLEN,
  output logic [2:0]              S_AWSIZE,
  output logic [1:0]              S_AWBURST,
  output logic [ID_WIDTH-1:0]     S_AWID,
  output logic                    S_AWVALID,
  input  logic                    S_AWREADY,
  output logic [AXI_DWIDTH-1:0]   S_WDATA,
  output logic [AXI_DWIDTH/8-1:0] S_WSTRB,
  output logic                    S_WLAST,
  output logic                    S_WVALID,
  input  logic                    S_WREADY,
  input  logic [ID_WIDTH-1:0]     S_BID,
  input  logic [1:0]              S_BRESP,
  input  logic                    S_BVALID,
  output logic                    S_BREADY,
  output logic [ADDR_WIDTH-1:0]   S_ARADDR,
  output logic [3:0]              S_ARLEN,
  output logic [2:0]              S_ARSIZE,
  output logic [1:0]              S_ARBURST,
  output logic [ID_WIDTH-1:0]     S_ARID,
  output logic                    S_ARVALID,
  input  logic                    S_ARREADY,
  input  logic [ID_WIDTH-1:0]     S_RID,
  input  logic [AXI_DWIDTH-1:0]   S_RDATA,
  input  logic [1:0]              S_RRESP,
  input  logic                    S_RLAST,
  input  logic                    S_RVALID,
  output logic                    S_RREADY,
  output logic [1:0]              GRANT,
  output logic                    PROTO_ERR
);
  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA} state_t;
  state_t state, state_d;
  logic       rr_ptr;
  logic [3:0] cnt;
  logic [3:0] len;
  logic g, req0, req1, win1, win_aw;
  logic aw_ph, w_ph, b_ph, ar_ph, r_ph;
  logic g_awvalid, g_wvalid, g_wlast, g_bready, g_arvalid, g_rready;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, done;
  assign g    = GRANT[1];
  assign req0 = M0_AWVALID | M0_ARVALID;
  assign req1 = M1_AWVALID | M1_ARVALID;
  assign win1 = req1 & (~req0 | rr_ptr);
  assign win_aw = win1 ? M1_AWVALID : M0_AWVALID;
  assign aw_ph = state == WR_ADDR;
  assign w_ph  = state == WR_DATA;
  assign b_ph  = state == WR_RESP;
  assign ar_ph = state == RD_ADDR;
  assign r_ph  = state == RD_DATA;
  assign g_awvalid = g ? M1_AWVALID : M0_AWVALID;
  assign g_wvalid  = g ? M1_WVALID  : M0_WVALID;
  assign g_wlast   = g ? M1_WLAST   : M0_WLAST;
  assign g_bready  = g ? M1_BREADY  : M0_BREADY;
  assign g_arvalid = g ? M1_ARVALID : M0_ARVALID;
  assign g_rready  = g ? M1_RREADY  : M0_RREADY;
  assign S_AWADDR  = g ? M1_AWADDR  : M0_AWADDR;
  assign S_AWLEN   = g ? M1_AWLEN   : M0_AWLEN;
  assign S_AWSIZE  = g ? M1_AWSIZE  : M0_AWSIZE;
  assign S_AWBURST = g ? M1_AWBURST : M0_AWBURST;
  assign S_AWID    = g ? M1_AWID    : M0_AWID;
  assign S_AWVALID = aw_ph & g_awvalid;
  assign S_WDATA   = g ? M1_WDATA   : M0_WDATA;
  assign S_WSTRB   = g ? M1_WSTRB   : M0_WSTRB;
  assign S_WLAST   = cnt == len;
  assign S_WVALID  = w_ph & g_wvalid;
  assign S_BREADY  = b_ph & g_bready;
  assign S_ARADDR  = g ? M1_ARADDR  : M0_ARADDR;
  assign S_ARLEN   = g ? M1_ARLEN   : M0_ARLEN;
  assign S_ARSIZE  = g ? M1_ARSIZE  : M0_ARSIZE;
  assign S_ARBURST = g ? M1_ARBURST : M0_ARBURST;
  assign S_ARID    = g ? M1_ARID    : M0_ARID;
  assign S_ARVALID = ar_ph & g_arvalid;
  assign S_RREADY  = r_ph & g_rready;
  assign M0_AWREADY = ~g & aw_ph & S_AWREADY;
  assign M1_AWREADY =  g & aw_ph & S_AWREADY;
  assign M0_WREADY  = ~g & w_ph & S_WREADY;
  assign M1_WREADY  =  g & w_ph & S_WREADY;
  assign M0_BVALID  = ~g & b_ph & S_BVALID;
  assign M1_BVALID  =  g & b_ph & S_BVALID;
  assign M0_ARREADY = ~g & ar_ph & S_ARREADY;
  assign M1_ARREADY =  g & ar_ph & S_ARREADY;
  assign M0_RVALID  = ~g & r_ph & S_RVALID;
  assign M1_RVALID  =  g & r_ph & S_RVALID;
  assign M0_BID = S_BID;
  assign M1_BID = S_BID;
  assign M0_BRESP = S_BRESP;
  assign M1_BRESP = S_BRESP;
  assign M0_RID = S_RID;
  assign M1_RID = S_RID;
  assign M0_RDATA = S_RDATA;
  assign M1_RDATA = S_RDATA;
  assign M0_RRESP = S_RRESP;
  assign M1_RRESP = S_RRESP;
  assign M0_RLAST = S_RLAST;
  assign M1_RLAST = S_RLAST;
  assign aw_hs = S_AWVALID & S_AWREADY;
  assign w_hs  = S_WVALID & S_WREADY;
  assign b_hs  = S_BREADY & S_BVALID;
  assign ar_hs = S_ARVALID & S_ARREADY;
  assign r_hs  = S_RREADY & S_RVALID;
  assign done  = b_hs | (r_hs & S_RLAST);
  // state register
  always_ff @(posedge ACLK)
    state <= ~ARESETN ? IDLE : state_d;
  // next-state: one burst at a time, AW preferred over AR for the winner
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = (req0 | req1) ? (win_aw ? WR_ADDR : RD_ADDR) : IDLE;
      WR_ADDR: state_d = aw_hs ? WR_DATA : WR_ADDR;
      WR_DATA: state_d = (w_hs & S_WLAST) ? WR_RESP : WR_DATA;
      WR_RESP: state_d = b_hs ? IDLE : WR_RESP;
      RD_ADDR: state_d = ar_hs ? RD_DATA : RD_ADDR;
      RD_DATA: state_d = (r_hs & S_RLAST) ? IDLE : RD_DATA;
      default: state_d = IDLE;
    endcase
  end
  // grant, round-robin pointer, beat counter and the sticky WLAST check
  always_ff @(posedge ACLK) begin
    if (~ARESETN) begin
      GRANT     <= 2'b00;
      rr_ptr    <= 1'b0;
      cnt       <= 4'd0;
      len       <= 4'd0;
      PROTO_ERR <= 1'b0;
    end else begin
      if (state == IDLE && (req0 | req1)) GRANT <= {win1, ~win1};
      if (done) begin
        GRANT  <= 2'b00;
        rr_ptr <= ~rr_ptr;
      end
      if (aw_hs) begin
        len <= S_AWLEN;
        cnt <= 4'd0;
      end
      if (w_hs) cnt <= cnt + 4'd1;
      if (w_hs && g_wlast != S_WLAST) PROTO_ERR <= 1'b1;
    end
  end
endmodule

// File: tb/tb_axi_bridge_2m_arbiter.sv
// tb_axi_bridge_2m_arbiter: directed self-checking bench for the two-master arbiter
`timescale 1ns/1ps
module tb_axi_bridge_2m_arbiter;
  logic ACLK = 0, ARESETN;
  logic [31:0] M0_AWADDR, M1_AWADDR, M0_ARADDR, M1_ARADDR, S_AWADDR, S_ARADDR;
  logic [3:0]  M0_AWLEN, M1_AWLEN, M0_ARLEN, M1_ARLEN, S_AWLEN, S_ARLEN;
  logic [2:0]  M0_AWSIZE, M1_AWSIZE, M0_ARSIZE, M1_ARSIZE, S_AWSIZE, S_ARSIZE;
  logic [1:0]  M0_AWBURST, M1_AWBURST, M0_ARBURST, M1_ARBURST, S_AWBURST, S_ARBURST;
  logic [4:0]  M0_AWID, M1_AWID, M0_ARID, M1_ARID, S_AWID, S_ARID;
  logic        M0_AWVALID, M1_AWVALID, M0_AWREADY, M1_AWREADY, S_AWVALID, S_AWREADY;
  logic [63:0] M0_WDATA, M1_WDATA, S_WDATA, M0_RDATA, M1_RDATA, S_RDATA;
  logic [7:0]  M0_WSTRB, M1_WSTRB, S_WSTRB;
  logic        M0_WLAST, M1_WLAST, S_WLAST, M0_WVALID, M1_WVALID, S_WVALID;
  logic        M0_WREADY, M1_WREADY, S_WREADY;
  logic [4:0]  M0_BID, M1_BID, S_BID, M0_RID, M1_RID, S_RID;
  logic [1:0]  M0_BRESP, M1_BRESP, S_BRESP, M0_RRESP, M1_RRESP, S_RRESP;
  logic        M0_BVALID, M1_BVALID, S_BVALID, M0_BREADY, M1_BREADY, S_BREADY;
  logic        M0_ARVALID, M1_ARVALID, S_ARVALID, M0_ARREADY, M1_ARREADY, S_ARREADY;
  logic        M0_RLAST, M1_RLAST, S_RLAST, M0_RVALID, M1_RVALID, S_RVALID;
  logic        M0_RREADY, M1_RREADY, S_RREADY;
  logic [1:0]  GRANT;
  logic        PROTO_ERR;
  int errors = 0, checks = 0;

  axi_bridge_2m_arbiter dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .M0_AWADDR(M0_AWADDR), .M0_AWLEN(M0_AWLEN), .M0_AWSIZE(M0_AWSIZE), .M0_AWBURST(M0_AWBURST),
    .M0_AWID(M0_AWID), .M0_AWVALID(M0_AWVALID), .M0_AWREADY(M0_AWREADY),
    .M0_WDATA(M0_WDATA), .M0_WSTRB(M0_WSTRB), .M0_WLAST(M0_WLAST), .M0_WVALID(M0_WVALID), .M0_WREADY(M0_WREADY),
    .M0_BID(M0_BID), .M0_BRESP(M0_BRESP), .M0_BVALID(M0_BVALID), .M0_BREADY(M0_BREADY),
    .M0_ARADDR(M0_ARADDR), .M0_ARLEN(M0_ARLEN), .M0_ARSIZE(M0_ARSIZE), .M0_ARBURST(M0_ARBURST),
    .M0_ARID(M0_ARID), .M0_ARVALID(M0_ARVALID), .M0_ARREADY(M0_ARREADY),
    .M0_RID(M0_RID), .M0_RDATA(M0_RDATA), .M0_RRESP(M0_RRESP), .M0_RLAST(M0_RLAST), .M0_RVALID(M0_RVALID), .M0_RREADY(M0_RREADY),
    .M1_AWADDR(M1_AWADDR), .M1_AWLEN(M1_AWLEN), .M1_AWSIZE(M1_AWSIZE), .M1_AWBURST(M1_AWBURST),
    .M1_AWID(M1_AWID), .M1_AWVALID(M1_AWVALID), .M1_AWREADY(M1_AWREADY),
    .M1_WDATA(M1_WDATA), .M1_WSTRB(M1_WSTRB), .M1_WLAST(M1_WLAST), .M1_WVALID(M1_WVALID), .M1_WREADY(M1_WREADY),
    .M1_BID(M1_BID), .M1_BRESP(M1_BRESP), .M1_BVALID(M1_BVALID), .M1_BREADY(M1_BREADY),
    .M1_ARADDR(M1_ARADDR), .M1_ARLEN(M1_ARLEN), .M1_ARSIZE(M1_ARSIZE), .M1_ARBURST(M1_ARBURST),
    .M1_ARID(M1_ARID), .M1_ARVALID(M1_ARVALID), .M1_ARREADY(M1_ARREADY),
    .M1_RID(M1_RID), .M1_RDATA(M1_RDATA), .M1_RRESP(M1_RRESP), .M1_RLAST(M1_RLAST), .M1_RVALID(M1_RVALID), .M1_RREADY(M1_RREADY),
    .S_AWADDR(S_AWADDR), .S_AWLEN(S_AWLEN), .S_AWSIZE(S_AWSIZE), .S_AWBURST(S_AWBURST),
    .S_AWID(S_AWID), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WLAST(S_WLAST), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BID(S_BID), .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN), .S_ARSIZE(S_ARSIZE), .S_ARBURST(S_ARBURST),
    .S_ARID(S_ARID), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RID(S_RID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RLAST(S_RLAST), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .GRANT(GRANT), .PROTO_ERR(PROTO_ERR)
  );

  always #5 ACLK = ~ACLK;

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  task automatic clear_inputs;
    {M0_AWADDR, M0_AWLEN, M0_AWSIZE, M0_AWBURST, M0_AWID, M0_AWVALID} = '0;
    {M1_AWADDR, M1_AWLEN, M1_AWSIZE, M1_AWBURST, M1_AWID, M1_AWVALID} = '0;
    {M0_WDATA, M0_WSTRB, M0_WLAST, M0_WVALID, M0_BREADY} = '0;
    {M1_WDATA, M1_WSTRB, M1_WLAST, M1_WVALID, M1_BREADY} = '0;
    {M0_ARADDR, M0_ARLEN, M0_ARSIZE, M0_ARBURST, M0_ARID, M0_ARVALID, M0_RREADY} = '0;
    {M1_ARADDR, M1_ARLEN, M1_ARSIZE, M1_ARBURST, M1_ARID, M1_ARVALID, M1_RREADY} = '0;
    {S_BID, S_BRESP, S_BVALID, S_RID, S_RDATA, S_RRESP, S_RLAST, S_RVALID} = '0;
    S_AWREADY = 1;
    S_WREADY  = 1;
    S_ARREADY = 1;
  endtask

  task automatic do_reset;
    clear_inputs();
    ARESETN = 0;
    tick();
    tick();
    ARESETN = 1;
  endtask

  task automatic test_reset;
    logic [15:0] hs;
    do_reset();
    M0_AWVALID = 0;
    #1;
    hs = {S_AWVALID, S_WVALID, S_BREADY, S_ARVALID, S_RREADY, M0_AWREADY, M0_WREADY, M0_BVALID,
          M0_ARREADY, M0_RVALID, M1_AWREADY, M1_WREADY, M1_BVALID, M1_ARREADY, M1_RVALID, PROTO_ERR};
    checks++; if (GRANT !== 2'b00) begin errors++; $display("FAIL reset_grant got=%b exp=00", GRANT); end
    checks++; if (hs !== 16'h0) begin errors++; $display("FAIL reset_handshakes got=%h exp=0000", hs); end
  endtask

  task automatic test_write_m0;
    do_reset();
    M0_AWVALID = 1; M0_AWLEN = 3; M0_AWID = 5'h0A; M0_AWADDR = 32'h1000;
    #1;
    checks++; if (GRANT !== 2'b00 || M0_AWREADY !== 0) begin errors++; $display("FAIL wr_idle grant=%b awready=%b exp=00/0", GRANT, M0_AWREADY); end
    tick();
    checks++; if (GRANT !== 2'b01) begin errors++; $display("FAIL wr_grant got=%b exp=01", GRANT); end
    checks++; if ({S_AWVALID, S_AWID, S_AWLEN, M0_AWREADY, M1_AWREADY} !== {1'b1, 5'h0A, 4'd3, 1'b1, 1'b0})
      begin errors++; $display("FAIL wr_aw got v=%b id=%h len=%0d r0=%b r1=%b", S_AWVALID, S_AWID, S_AWLEN, M0_AWREADY, M1_AWREADY); end
    checks++; if (S_AWADDR !== 32'h1000) begin errors++; $display("FAIL wr_awaddr got=%h exp=00001000", S_AWADDR); end
    tick();
    M0_AWVALID = 0; M0_WVALID = 1; M0_WSTRB = 8'hFF;
    for (int b = 0; b < 4; b++) begin
      M0_WDATA = 64'hA5A5_0000_0000_0000 + 64'(b); M0_WLAST = (b == 3);
      #1;
      checks++; if ({S_WVALID, S_WLAST, M0_WREADY, M1_WREADY} !== {1'b1, b == 3, 1'b1, 1'b0})
        begin errors++; $display("FAIL wr_beat%0d got v=%b last=%b r0=%b r1=%b", b, S_WVALID, S_WLAST, M0_WREADY, M1_WREADY); end
      checks++; if (S_WDATA !== 64'hA5A5_0000_0000_0000 + 64'(b)) begin errors++; $display("FAIL wr_data%0d got=%h", b, S_WDATA); end
      tick();
    end
    M0_WVALID = 0; M0_BREADY = 1; S_BVALID = 1; S_BID = 5'h0A;
    #1;
    checks++; if ({M0_BVALID, M0_BID, S_BREADY, M1_BVALID} !== {1'b1, 5'h0A, 1'b1, 1'b0})
      begin errors++; $display("FAIL wr_b got bv0=%b bid=%h bready=%b bv1=%b", M0_BVALID, M0_BID, S_BREADY, M1_BVALID); end
    tick();
    S_BVALID = 0; M0_BREADY = 0;
    #1;
    checks++; if (GRANT !== 2'b00 || PROTO_ERR !== 0) begin errors++; $display("FAIL wr_end grant=%b perr=%b exp=00/0", GRANT, PROTO_ERR); end
  endtask

  task automatic test_read_rr;
    do_reset();
    M0_ARVALID = 1; M0_ARID = 5'h01; M1_ARVALID = 1; M1_ARID = 5'h02;
    tick();
    checks++; if ({GRANT, S_ARVALID, S_ARID, M0_ARREADY, M1_ARREADY} !== {2'b01, 1'b1, 5'h01, 1'b1, 1'b0})
      begin errors++; $display("FAIL rr_first got g=%b v=%b id=%h r0=%b r1=%b", GRANT, S_ARVALID, S_ARID, M0_ARREADY, M1_ARREADY); end
    tick();
    M0_ARVALID = 0; M0_RREADY = 1; M1_RREADY = 1; S_RVALID = 1; S_RLAST = 1; S_RID = 5'h01; S_RDATA = 64'h1111;
    #1;
    checks++; if ({M0_RVALID, M1_RVALID, M0_RID, S_RREADY} !== {1'b1, 1'b0, 5'h01, 1'b1})
      begin errors++; $display("FAIL rr_r0 got v0=%b v1=%b id=%h rready=%b", M0_RVALID, M1_RVALID, M0_RID, S_RREADY); end
    tick();
    S_RVALID = 0;
    #1;
    checks++; if (GRANT !== 2'b00) begin errors++; $display("FAIL rr_gap got=%b exp=00", GRANT); end
    tick();
    checks++; if ({GRANT, S_ARID, M1_ARREADY, M0_ARREADY} !== {2'b10, 5'h02, 1'b1, 1'b0})
      begin errors++; $display("FAIL rr_second got g=%b id=%h r1=%b r0=%b", GRANT, S_ARID, M1_ARREADY, M0_ARREADY); end
    tick();
    M1_ARVALID = 0; S_RVALID = 1; S_RLAST = 1; S_RID = 5'h02;
    #1;
    checks++; if ({M1_RVALID, M0_RVALID, M1_RID} !== {1'b1, 1'b0, 5'h02})
      begin errors++; $display("FAIL rr_r1 got v1=%b v0=%b id=%h", M1_RVALID, M0_RVALID, M1_RID); end
    tick();
    S_RVALID = 0;
    #1;
    checks++; if (GRANT !== 2'b00) begin errors++; $display("FAIL rr_end got=%b exp=00", GRANT); end
  endtask

  task automatic test_aw_before_ar;
    do_reset();
    M1_AWVALID = 1; M1_AWLEN = 0; M1_ARVALID = 1; M1_ARLEN = 0;
    tick();
    checks++; if ({GRANT, S_AWVALID, S_ARVALID} !== {2'b10, 1'b1, 1'b0})
      begin errors++; $display("FAIL awar_grant got g=%b aw=%b ar=%b", GRANT, S_AWVALID, S_ARVALID); end
    tick();
    M1_AWVALID = 0; M1_WVALID = 1; M1_WLAST = 1;
    #1;
    checks++; if ({S_WVALID, S_WLAST, M1_WREADY} !== 3'b111) begin errors++; $display("FAIL awar_beat got v=%b last=%b r=%b", S_WVALID, S_WLAST, M1_WREADY); end
    tick();
    M1_WVALID = 0; S_BVALID = 1; M1_BREADY = 1;
    #1;
    checks++; if (M1_BVALID !== 1) begin errors++; $display("FAIL awar_b got=%b exp=1", M1_BVALID); end
    tick();
    S_BVALID = 0; M1_BREADY = 0;
    #1;
    checks++; if (GRANT !== 2'b00 || S_ARVALID !== 0) begin errors++; $display("FAIL awar_gap g=%b ar=%b exp=00/0", GRANT, S_ARVALID); end
    tick();
    checks++; if ({GRANT, S_ARVALID} !== {2'b10, 1'b1}) begin errors++; $display("FAIL awar_read g=%b ar=%b", GRANT, S_ARVALID); end
    tick();
    M1_ARVALID = 0; S_RVALID = 1; S_RLAST = 1; M1_RREADY = 1;
    #1;
    checks++; if (M1_RVALID !== 1) begin errors++; $display("FAIL awar_r got=%b exp=1", M1_RVALID); end
    tick();
    S_RVALID = 0;
  endtask

  task automatic test_wlast_mismatch;
    do_reset();
    M0_AWVALID = 1; M0_AWLEN = 1;
    tick();
    tick();
    M0_AWVALID = 0; M0_WVALID = 1; M0_WLAST = 1;
    #1;
    checks++; if (S_WLAST !== 0 || PROTO_ERR !== 0) begin errors++; $display("FAIL perr_beat1 last=%b perr=%b exp=0/0", S_WLAST, PROTO_ERR); end
    tick();
    M0_WLAST = 0;
    #1;
    checks++; if (S_WLAST !== 1 || PROTO_ERR !== 1) begin errors++; $display("FAIL perr_beat2 last=%b perr=%b exp=1/1", S_WLAST, PROTO_ERR); end
    tick();
    M0_WVALID = 0; S_BVALID = 1; M0_BREADY = 1;
    tick();
    S_BVALID = 0; M0_BREADY = 0;
    tick();
    checks++; if (PROTO_ERR !== 1 || GRANT !== 2'b00) begin errors++; $display("FAIL perr_sticky perr=%b g=%b exp=1/00", PROTO_ERR, GRANT); end
    ARESETN = 0;
    tick();
    checks++; if (PROTO_ERR !== 0) begin errors++; $display("FAIL perr_clear got=%b exp=0", PROTO_ERR); end
    ARESETN = 1;
  endtask

  task automatic test_len15;
    do_reset();
    M0_AWVALID = 1; M0_AWLEN = 15;
    tick();
    tick();
    M0_AWVALID = 0; M0_WVALID = 1;
    for (int b = 0; b < 16; b++) begin
      M0_WLAST = (b == 15);
      #1;
      checks++; if (S_WLAST !== (b == 15) || M0_WREADY !== 1) begin errors++; $display("FAIL len15_beat%0d last=%b r=%b", b, S_WLAST, M0_WREADY); end
      tick();
    end
    M0_WLAST = 1;
    #1;
    checks++; if (M0_WREADY !== 0 || S_WVALID !== 0) begin errors++; $display("FAIL len15_extra r=%b v=%b exp=0/0", M0_WREADY, S_WVALID); end
    M0_WVALID = 0; S_BVALID = 1; M0_BREADY = 1;
    tick();
    S_BVALID = 0; M0_BREADY = 0;
    #1;
    checks++; if (GRANT !== 2'b00 || PROTO_ERR !== 0) begin errors++; $display("FAIL len15_end g=%b perr=%b exp=00/0", GRANT, PROTO_ERR); end
  endtask

  task automatic test_reset_mid_read;
    logic [9:0] hs;
    do_reset();
    M0_ARVALID = 1; M0_ARLEN = 7;
    tick();
    tick();
    M0_ARVALID = 0; S_RVALID = 1; S_RLAST = 0; M0_RREADY = 1;
    #1;
    checks++; if (M0_RVALID !== 1) begin errors++; $display("FAIL midrst_rv got=%b exp=1", M0_RVALID); end
    tick();
    tick();
    ARESETN = 0;
    tick();
    hs = {S_AWVALID, S_WVALID, S_BREADY, S_ARVALID, S_RREADY, M0_RVALID, M0_ARREADY, M1_RVALID, M1_ARREADY, M0_BVALID};
    checks++; if (GRANT !== 2'b00 || hs !== 10'h0) begin errors++; $display("FAIL midrst_idle g=%b hs=%h exp=00/000", GRANT, hs); end
    ARESETN = 1; S_RVALID = 0; M0_RREADY = 0;
    M1_ARVALID = 1; M1_ARLEN = 1; M1_ARID = 5'h07;
    tick();
    checks++; if (GRANT !== 2'b10 || S_ARID !== 5'h07) begin errors++; $display("FAIL midrst_m1 g=%b id=%h exp=10/07", GRANT, S_ARID); end
    tick();
    M1_ARVALID = 0; S_RVALID = 1; S_RLAST = 0; M1_RREADY = 1;
    tick();
    S_RLAST = 1;
    #1;
    checks++; if (M1_RVALID !== 1 || M1_RLAST !== 1) begin errors++; $display("FAIL midrst_last v=%b l=%b exp=1/1", M1_RVALID, M1_RLAST); end
    tick();
    S_RVALID = 0;
    #1;
    checks++; if (GRANT !== 2'b00) begin errors++; $display("FAIL midrst_end got=%b exp=00", GRANT); end
  endtask

  task automatic test_b_stall;
    do_reset();
    M0_AWVALID = 1; M0_AWLEN = 0;
    tick();
    tick();
    M0_AWVALID = 0; M0_WVALID = 1; M0_WLAST = 1;
    tick();
    M0_WVALID = 0; S_BVALID = 1; M0_BREADY = 0; M1_ARVALID = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if ({GRANT, M0_BVALID, S_BREADY, M1_ARREADY} !== {2'b01, 1'b1, 1'b0, 1'b0})
        begin errors++; $display("FAIL bstall_%0d g=%b bv=%b br=%b ar1=%b", i, GRANT, M0_BVALID, S_BREADY, M1_ARREADY); end
      tick();
    end
    M0_BREADY = 1;
    tick();
    S_BVALID = 0; M0_BREADY = 0;
    #1;
    checks++; if (GRANT !== 2'b00) begin errors++; $display("FAIL bstall_idle got=%b exp=00", GRANT); end
    tick();
    checks++; if (GRANT !== 2'b10 || M1_ARREADY !== 1) begin errors++; $display("FAIL bstall_m1 g=%b ar=%b exp=10/1", GRANT, M1_ARREADY); end
    tick();
    M1_ARVALID = 0; S_RVALID = 1; S_RLAST = 1; M1_RREADY = 1;
    tick();
    S_RVALID = 0;
    #1;
    checks++; if (GRANT !== 2'b00) begin errors++; $display("FAIL bstall_end got=%b exp=00", GRANT); end
  endtask

  initial begin
    test_reset();
    test_write_m0();
    test_read_rr();
    test_aw_before_ar();
    test_wlast_mismatch();
    test_len15();
    test_reset_mid_read();
    test_b_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axi_bridge_2m_arbiter.md
Name: axi_bridge_2m_arbiter

Overview:
- Two-master AXI3 arbiter that shares the single AXI slave port of the AXI-to-AHB-Lite bridge (64-bit data, 5-bit ID, 4-bit LEN) between two requesters.
- Serialises transactions: exactly one read or write burst is in flight at a time, so response routing needs no ID remapping.
- Regenerates WLAST from a beat counter and flags masters whose WLAST disagrees with their AWLEN.
- Sits on ACLK, between the interconnect masters and the bridge slave interface.

Parameters:
- ADDR_WIDTH, 32, AW/AR address width.
- AXI_DWIDTH, 64, W/R data width; WSTRB width = AXI_DWIDTH/8.
- ID_WIDTH, 5, AxID/BID/RID width; passed through unchanged.

Ports:
- ACLK  in  1  clock, rising edge.
- ARESETN  in  1  reset, synchronous, active-low.
- Mn_AWADDR/AWLEN/AWSIZE/AWBURST/AWID/AWVALID  in  32/4/3/2/5/1  master n write address (n=0,1).
- Mn_AWREADY  out  1  master n write address ready.
- Mn_WDATA/WSTRB/WLAST/WVALID  in  64/8/1/1  master n write data.
- Mn_WREADY  out  1  master n write data ready.
- Mn_BID/BRESP/BVALID  out  5/2/1  master n write response.
- Mn_BREADY  in  1  master n write response ready.
- Mn_ARADDR/ARLEN/ARSIZE/ARBURST/ARID/ARVALID  in  32/4/3/2/5/1  master n read address.
- Mn_ARREADY  out  1  master n read address ready.
- Mn_RID/RDATA/RRESP/RLAST/RVALID  out  5/64/2/1/1  master n read data.
- Mn_RREADY  in  1  master n read data ready.
- S_AW*, S_W*, S_AR*, S_BREADY, S_RREADY  out  as above  to bridge slave port.
- S_AWREADY, S_WREADY, S_B*, S_ARREADY, S_R*  in  as above  from bridge.
- GRANT  out  2  one-hot owner of the current transaction; 00 when idle.
- PROTO_ERR  out  1  sticky WLAST-mismatch flag.

Behaviour:
- States: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA. State, grant, rr_ptr, beat counter, latched len and PROTO_ERR are registers.
- Reset (ARESETN=0 at a rising edge, including mid-burst):
  - state=IDLE, GRANT=00, rr_ptr=0 (M0 preferred), PROTO_ERR=0, counter=0.
  - All S_*VALID, S_BREADY, S_RREADY, Mn_*READY, Mn_BVALID and Mn_RVALID are 0 from the cycle after that edge.
  - No attempt is made to complete an abandoned burst.
- Arbitration in IDLE:
  - reqn = Mn_AWVALID | Mn_ARVALID. If both masters request, the master selected by rr_ptr wins; otherwise the sole requester wins.
  - The winning master's AW is chosen over its AR when both are valid.
  - Next edge: GRANT loads the winner and state moves to WR_ADDR or RD_ADDR. Arbitration latency is 1 cycle; in IDLE all ready/valid outputs are 0.
- Routing:
  - In every non-IDLE state, the granted master's channel signals pass combinationally to/from S_*.
  - The non-granted master sees all its READY and VALID outputs at 0.
  - Data and ID fields on the non-granted master's outputs are don't-care.
- WR_ADDR:
  - S_AWVALID = Mg_AWVALID. On the S_AWVALID & S_AWREADY handshake, latch AWLEN, clear the counter, go to WR_DATA.
  - Mg_WREADY is held 0 in WR_ADDR.
- WR_DATA:
  - W passes through, except S_WLAST = (counter == latched len).
  - Each W handshake increments the counter.
  - If Mg_WLAST != S_WLAST on any handshake beat, PROTO_ERR is set (it clears only on reset).
  - The handshake with S_WLAST=1 moves to WR_RESP. Extra master beats after that point are not accepted.
- WR_RESP: B passes through. The S_BVALID & Mg_BREADY handshake clears GRANT, toggles rr_ptr to the other master and returns to IDLE.
- RD_ADDR: AR passes through. The handshake moves to RD_DATA.
- RD_DATA: R passes through. The handshake with S_RLAST=1 clears GRANT, toggles rr_ptr and returns to IDLE.
- Back-to-back: a new grant is issued on the cycle after returning to IDLE, so there is at least one idle cycle between transactions.
- Length boundaries: LEN=0 is a single beat with S_WLAST=1 on the first beat. LEN=15 is 16 beats; the 4-bit counter does not wrap before the last beat.
- A request deasserted in IDLE before being granted is simply not served; AXI forbids this, but it must not hang the arbiter.

Test Plan:
- Reset, then M0 write AWLEN=3, AWID=5'h0A, WLAST on beat 4 → GRANT=01 one cycle after AWVALID; 4 beats reach S_W with S_WLAST on beat 4; M0 gets BID=0A; PROTO_ERR=0; M1 readies stay 0 throughout.
- M0 and M1 both assert ARVALID in the same cycle → M0 served first (rr_ptr=0), then M1; RDATA/RID are delivered only to the owning master; GRANT sequence 01, 00, 10.
- M1 asserts AWVALID and ARVALID together, LEN=0 → write served first with a single beat and S_WLAST=1; the read follows after one idle cycle.
- M0 write AWLEN=1 with WLAST asserted on beat 1 → S_WLAST=0 on beat 1 and 1 on beat 2; PROTO_ERR=1 and remains 1 until reset.
- ARESETN low in RD_DATA after beat 2 of an ARLEN=7 read → the next cycle has GRANT=00, state IDLE, all valid/ready outputs 0; a fresh M1 read then completes normally.
- Bridge holds S_BVALID=1 while M0_BREADY=0 for 5 cycles → state stays WR_RESP and GRANT stays 01; a pending M1 request waits until the B handshake, then is granted.
